// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types for the cache-to-AXI arbiter: transfer type codes, FSM encodings,
// default AXI IDs and the type-to-burst mapping used by both the read and write paths.
package cache_axi_arbiter_pkg;

  localparam logic [3:0] IC_ID_DEFAULT = 4'd0;
  localparam logic [3:0] DC_ID_DEFAULT = 4'd1;

  typedef enum logic [2:0] {
    XFER_BYTE = 3'd0,
    XFER_HALF = 3'd1,
    XFER_WORD = 3'd2,
    XFER_LINE = 3'd4
  } xfer_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW   = 2'd1,
    WR_W    = 2'd2,
    WR_B    = 2'd3
  } wr_state_t;

  // A cache line is four 32-bit beats; everything else is a single beat.
  function automatic logic [7:0] axi_len(input logic [2:0] t);
    return (t == XFER_LINE) ? 8'd3 : 8'd0;
  endfunction

  function automatic logic [2:0] axi_size(input logic [2:0] t);
    return (t == XFER_LINE) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/cache_axi_arbiter_axi_wr_channel.sv
// D-cache write path: latches one word/line write and drives it out over AXI AW, W and B,
// exposing its busy state and line address for read-after-write hazard detection.
module axi_wr_channel
  import cache_axi_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready,
  output logic         busy,
  output logic [27:0]  line
);

  wr_state_t    state;
  logic [31:0]  lat_addr;
  logic [2:0]   lat_type;
  logic [3:0]   lat_strb;
  logic [127:0] lat_data;
  logic [1:0]   cnt;

  assign wr_rdy  = (state == WR_IDLE) && !reset;
  assign busy    = (state != WR_IDLE);
  assign line    = lat_addr[31:4];
  assign awaddr  = lat_addr;
  assign awlen   = axi_len(lat_type);
  assign awsize  = axi_size(lat_type);
  assign awvalid = (state == WR_AW);
  assign wvalid  = (state == WR_W);
  assign bready  = (state == WR_B);
  assign wdata   = wvalid ? lat_data[{cnt, 5'b00000} +: 32] : 32'h0000_0000;
  assign wstrb   = !wvalid ? 4'h0 : ((lat_type == XFER_LINE) ? 4'hF : lat_strb);
  assign wlast   = wvalid && (cnt == awlen[1:0]);

  // Write FSM: accept, address phase, data beats, then wait for the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WR_IDLE;
      lat_addr <= 32'h0000_0000;
      lat_type <= 3'd0;
      lat_strb <= 4'h0;
      lat_data <= 128'h0;
      cnt      <= 2'd0;
    end else begin
      case (state)
        WR_IDLE: begin
          if (wr_req) begin
            lat_addr <= wr_addr;
            lat_type <= wr_type;
            lat_strb <= wr_wstrb;
            lat_data <= wr_data;
            cnt      <= 2'd0;
            state    <= WR_AW;
          end
        end
        WR_AW: begin
          if (awready) state <= WR_W;
        end
        WR_W: begin
          if (wready) begin
            if (wlast) begin
              cnt   <= 2'd0;
              state <= WR_B;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        WR_B: begin
          if (bvalid) state <= WR_IDLE;
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_axi_arbiter_chk.sv
// Protocol checker: a read beat must carry the ID of the read that is in flight.
module cache_axi_arbiter_chk (
  input logic       clk,
  input logic       reset,
  input logic       rvalid,
  input logic       rready,
  input logic [3:0] rid,
  input logic [3:0] exp_id
);

  rid_match: assert property (@(posedge clk) disable iff (reset)
    (rvalid && rready) |-> (rid == exp_id));

endmodule

// File: rtl/cache_axi_arbiter.sv
// Arbitrates I-cache and D-cache reads onto one AXI read channel (D first, one outstanding)
// and forwards D-cache writes through axi_wr_channel, holding back reads to a line being written.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter logic [3:0] IC_ID = IC_ID_DEFAULT,
  parameter logic [3:0] DC_ID = DC_ID_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  output logic [31:0]  i_ret_data,
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  d_ret_data,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_t   rd_state;
  logic        rd_to_d;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic        wr_busy;
  logic [27:0] wr_line;
  logic        d_hazard;
  logic        i_hazard;
  logic        d_grant;
  logic        i_grant;
  logic        beat;

  // A read to the line currently being written must wait for the write to finish.
  assign d_hazard = wr_busy && (d_rd_addr[31:4] == wr_line);
  assign i_hazard = wr_busy && (i_rd_addr[31:4] == wr_line);
  assign d_grant  = (rd_state == RD_IDLE) && !reset && d_rd_req && !d_hazard;
  assign i_grant  = (rd_state == RD_IDLE) && !reset && i_rd_req && !i_hazard && !d_grant;
  assign d_rd_rdy = d_grant;
  assign i_rd_rdy = i_grant;

  assign arid    = ar_id;
  assign araddr  = ar_addr;
  assign arlen   = ar_len;
  assign arsize  = ar_size;
  assign arvalid = (rd_state == RD_AR);
  assign rready  = (rd_state == RD_R);
  assign beat    = (rd_state == RD_R) && rvalid;

  assign d_ret_valid = beat && rd_to_d;
  assign d_ret_last  = d_ret_valid && rlast;
  assign d_ret_data  = d_ret_valid ? rdata : 32'h0000_0000;
  assign i_ret_valid = beat && !rd_to_d;
  assign i_ret_last  = i_ret_valid && rlast;
  assign i_ret_data  = i_ret_valid ? rdata : 32'h0000_0000;

  // Read FSM: grant and latch one request, issue AR, stream R beats back to the owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rd_to_d  <= 1'b0;
      ar_id    <= 4'd0;
      ar_addr  <= 32'h0000_0000;
      ar_len   <= 8'd0;
      ar_size  <= 3'd0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (d_grant) begin
            rd_state <= RD_AR;
            rd_to_d  <= 1'b1;
            ar_id    <= DC_ID;
            ar_addr  <= d_rd_addr;
            ar_len   <= axi_len(d_rd_type);
            ar_size  <= axi_size(d_rd_type);
          end else if (i_grant) begin
            rd_state <= RD_AR;
            rd_to_d  <= 1'b0;
            ar_id    <= IC_ID;
            ar_addr  <= i_rd_addr;
            ar_len   <= axi_len(i_rd_type);
            ar_size  <= axi_size(i_rd_type);
          end
        end
        RD_AR: begin
          if (arready) rd_state <= RD_R;
        end
        RD_R: begin
          if (rvalid && rlast) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign awid = DC_ID;

  axi_wr_channel u_wr (
    .clk      (clk),
    .reset    (reset),
    .wr_req   (d_wr_req),
    .wr_type  (d_wr_type),
    .wr_addr  (d_wr_addr),
    .wr_wstrb (d_wr_wstrb),
    .wr_data  (d_wr_data),
    .wr_rdy   (d_wr_rdy),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready),
    .busy     (wr_busy),
    .line     (wr_line)
  );

  cache_axi_arbiter_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .rvalid (rvalid),
    .rready (rready),
    .rid    (rid),
    .exp_id (ar_id)
  );

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: a table of single read transactions plus
// hand-written sequences for arbitration, line writes, RAW hazard and mid-transfer reset.
module tb_cache_axi_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_rd_req, d_rd_req, d_wr_req;
  logic [2:0]   i_rd_type, d_rd_type, d_wr_type;
  logic [31:0]  i_rd_addr, d_rd_addr, d_wr_addr;
  logic [3:0]   d_wr_wstrb;
  logic [127:0] d_wr_data;
  logic         i_rd_rdy, d_rd_rdy, d_wr_rdy;
  logic         i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
  logic [31:0]  i_ret_data, d_ret_data;
  logic [3:0]   arid, rid, awid, wstrb;
  logic [31:0]  araddr, rdata, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        is_d;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
    logic [3:0]  exp_id;
  } rd_vec_t;

  rd_vec_t vecs[6];

  cache_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_read(input logic to_d, input logic [2:0] typ, input logic [31:0] addr);
    if (to_d) begin
      d_rd_req = 1'b1; d_rd_type = typ; d_rd_addr = addr;
    end else begin
      i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr;
    end
    #1;
    check("rd_rdy_grant", to_d ? d_rd_rdy : i_rd_rdy, 32'd1);
    step();
    d_rd_req = 1'b0;
    i_rd_req = 1'b0;
  endtask

  // Called one cycle after the grant: AR phase (with one stall) then all R beats.
  task automatic finish_read(input logic to_d, input logic [31:0] exp_addr, input logic [7:0] exp_len,
                             input logic [2:0] exp_size, input logic [3:0] exp_id,
                             input logic [31:0] base);
    arready = 1'b0;
    #1;
    check("arvalid", arvalid, 32'd1);
    check("araddr", araddr, exp_addr);
    check("arlen", arlen, {24'd0, exp_len});
    check("arsize", arsize, {29'd0, exp_size});
    check("arid", arid, {28'd0, exp_id});
    check("rready_in_ar", rready, 32'd0);
    step();
    arready = 1'b1;
    #1;
    check("arvalid_held", arvalid, 32'd1);
    check("araddr_held", araddr, exp_addr);
    step();
    arready = 1'b0;
    for (int b = 0; b <= int'(exp_len); b++) begin
      rvalid = 1'b1;
      rid    = exp_id;
      rdata  = base + 32'(b);
      rlast  = (b == int'(exp_len));
      #1;
      check("rready", rready, 32'd1);
      check("ret_valid", to_d ? d_ret_valid : i_ret_valid, 32'd1);
      check("ret_other_quiet", to_d ? i_ret_valid : d_ret_valid, 32'd0);
      check("ret_data", to_d ? d_ret_data : i_ret_data, base + 32'(b));
      check("ret_last", to_d ? d_ret_last : i_ret_last, (b == int'(exp_len)) ? 32'd1 : 32'd0);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 3'd0, 32'h0000_0101, 8'd0, 3'd0, 4'd1};
    vecs[1] = '{1'b0, 3'd1, 32'h0000_0202, 8'd0, 3'd1, 4'd0};
    vecs[2] = '{1'b1, 3'd2, 32'hBFAF_8000, 8'd0, 3'd2, 4'd1};
    vecs[3] = '{1'b0, 3'd4, 32'h0040_0010, 8'd3, 3'd2, 4'd0};
    vecs[4] = '{1'b1, 3'd4, 32'h8000_0020, 8'd3, 3'd2, 4'd1};
    vecs[5] = '{1'b0, 3'd2, 32'h1234_5678, 8'd0, 3'd2, 4'd0};

    reset = 1'b1;
    {i_rd_req, d_rd_req, d_wr_req} = 3'b000;
    {i_rd_type, d_rd_type, d_wr_type} = 9'd0;
    {i_rd_addr, d_rd_addr, d_wr_addr} = 96'd0;
    d_wr_wstrb = 4'h0;
    d_wr_data  = 128'h0;
    {arready, rvalid, rlast, awready, wready, bvalid} = 6'b000000;
    rid   = 4'd0;
    rdata = 32'h0;
    step();
    step();

    // Reset state, with requests present to show rdy stays low under reset.
    d_rd_req = 1'b1; i_rd_req = 1'b1; d_wr_req = 1'b1;
    #1;
    check("rst_d_rd_rdy", d_rd_rdy, 32'd0);
    check("rst_i_rd_rdy", i_rd_rdy, 32'd0);
    check("rst_d_wr_rdy", d_wr_rdy, 32'd0);
    check("rst_arvalid", arvalid, 32'd0);
    check("rst_awvalid", awvalid, 32'd0);
    check("rst_wvalid", wvalid, 32'd0);
    check("rst_rready", rready, 32'd0);
    check("rst_bready", bready, 32'd0);
    check("rst_awid", awid, 32'd1);
    d_rd_req = 1'b0; i_rd_req = 1'b0; d_wr_req = 1'b0;
    step();
    reset = 1'b0;
    #1;

    for (int v = 0; v < 6; v++) begin
      grant_read(vecs[v].is_d, vecs[v].typ, vecs[v].addr);
      finish_read(vecs[v].is_d, vecs[v].addr, vecs[v].exp_len, vecs[v].exp_size,
                  vecs[v].exp_id, 32'h1000_0000 * 32'(v + 1));
    end

    // Simultaneous line reads: D wins, I follows once the D burst ends.
    d_rd_req = 1'b1; d_rd_type = 3'd4; d_rd_addr = 32'h0000_1000;
    i_rd_req = 1'b1; i_rd_type = 3'd4; i_rd_addr = 32'h0000_2000;
    #1;
    check("both_d_rdy", d_rd_rdy, 32'd1);
    check("both_i_rdy", i_rd_rdy, 32'd0);
    step();
    d_rd_req = 1'b0;
    #1;
    check("both_i_wait", i_rd_rdy, 32'd0);
    finish_read(1'b1, 32'h0000_1000, 8'd3, 3'd2, 4'd1, 32'h0000_0100);
    #1;
    check("both_i_rdy_next", i_rd_rdy, 32'd1);
    step();
    i_rd_req = 1'b0;
    finish_read(1'b0, 32'h0000_2000, 8'd3, 3'd2, 4'd0, 32'h0000_0200);

    // Line write: four W beats, then a hazarding D read held off until B completes.
    d_wr_req = 1'b1; d_wr_type = 3'd4; d_wr_addr = 32'h1C00_0040; d_wr_wstrb = 4'h0;
    d_wr_data = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h0000_0000};
    #1;
    check("wr_rdy_line", d_wr_rdy, 32'd1);
    step();
    d_wr_req = 1'b0;
    #1;
    check("awvalid", awvalid, 32'd1);
    check("awaddr", awaddr, 32'h1C00_0040);
    check("awlen", awlen, 32'd3);
    check("awsize", awsize, 32'd2);
    check("wr_rdy_busy", d_wr_rdy, 32'd0);
    check("wvalid_in_aw", wvalid, 32'd0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    wready  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      check("wvalid", wvalid, 32'd1);
      check("wdata", wdata, 32'h11 * 32'(b));
      check("wstrb_line", wstrb, 32'hF);
      check("wlast", wlast, (b == 3) ? 32'd1 : 32'd0);
      check("bready_in_w", bready, 32'd0);
      step();
    end
    wready = 1'b0;
    #1;
    check("bready", bready, 32'd1);
    check("wvalid_after", wvalid, 32'd0);
    d_rd_req = 1'b1; d_rd_type = 3'd2; d_rd_addr = 32'h1C00_0048;
    #1;
    check("haz_rdy_0", d_rd_rdy, 32'd0);
    step();
    #1;
    check("haz_rdy_1", d_rd_rdy, 32'd0);
    check("haz_ar_1", arvalid, 32'd0);
    bvalid = 1'b1;
    #1;
    check("haz_rdy_bvalid", d_rd_rdy, 32'd0);
    check("haz_ar_bvalid", arvalid, 32'd0);
    step();
    bvalid = 1'b0;
    #1;
    check("haz_rdy_after_b", d_rd_rdy, 32'd1);
    check("haz_ar_after_b", arvalid, 32'd0);
    check("wr_rdy_after_b", d_wr_rdy, 32'd1);
    step();
    d_rd_req = 1'b0;
    finish_read(1'b1, 32'h1C00_0048, 8'd0, 3'd2, 4'd1, 32'h0000_00A0);

    // Word write accepted in the same cycle as an I read grant; both run in parallel.
    d_wr_req = 1'b1; d_wr_type = 3'd2; d_wr_addr = 32'h0000_0100; d_wr_wstrb = 4'h6;
    d_wr_data = {96'h0, 32'hDEAD_BEEF};
    i_rd_req = 1'b1; i_rd_type = 3'd2; i_rd_addr = 32'h0000_3000;
    #1;
    check("par_wr_rdy", d_wr_rdy, 32'd1);
    check("par_i_rdy", i_rd_rdy, 32'd1);
    step();
    d_wr_req = 1'b0; i_rd_req = 1'b0;
    #1;
    check("par_arvalid", arvalid, 32'd1);
    check("par_awvalid", awvalid, 32'd1);
    check("par_awlen", awlen, 32'd0);
    arready = 1'b1; awready = 1'b1;
    step();
    arready = 1'b0; awready = 1'b0;
    wready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 32'h0BAD_F00D;
    #1;
    check("par_i_ret", i_ret_data, 32'h0BAD_F00D);
    check("par_i_last", i_ret_last, 32'd1);
    check("par_wdata", wdata, 32'hDEAD_BEEF);
    check("par_wstrb", wstrb, 32'h6);
    check("par_wlast", wlast, 32'd1);
    step();
    wready = 1'b0; rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b1;
    #1;
    check("par_bready", bready, 32'd1);
    check("par_rready_done", rready, 32'd0);
    step();
    bvalid = 1'b0;
    #1;
    check("par_wr_idle", d_wr_rdy, 32'd1);

    // Reset mid-W and mid-R.
    d_wr_req = 1'b1; d_wr_type = 3'd4; d_wr_addr = 32'h0000_0600;
    d_wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    step();
    d_wr_req = 1'b0;
    awready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b1;
    step();
    wready = 1'b0;
    grant_read(1'b1, 3'd4, 32'h0000_0500);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h5555_0000; rlast = 1'b0;
    step();
    wready = 1'b1; rdata = 32'h5555_0001; d_rd_req = 1'b1; d_wr_req = 1'b1;
    #1;
    check("pre_rst_wvalid", wvalid, 32'd1);
    check("pre_rst_ret", d_ret_valid, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_rready", rready, 32'd0);
    check("mid_rst_ret_valid", d_ret_valid, 32'd0);
    check("mid_rst_ret_data", d_ret_data, 32'd0);
    check("mid_rst_wvalid", wvalid, 32'd0);
    check("mid_rst_wdata", wdata, 32'd0);
    check("mid_rst_wstrb", wstrb, 32'd0);
    check("mid_rst_wlast", wlast, 32'd0);
    check("mid_rst_bready", bready, 32'd0);
    check("mid_rst_arvalid", arvalid, 32'd0);
    check("mid_rst_araddr", araddr, 32'd0);
    check("mid_rst_d_rd_rdy", d_rd_rdy, 32'd0);
    check("mid_rst_d_wr_rdy", d_wr_rdy, 32'd0);
    step();
    reset = 1'b0; rvalid = 1'b0; wready = 1'b0;
    #1;
    check("post_rst_d_rd_rdy", d_rd_rdy, 32'd1);
    check("post_rst_d_wr_rdy", d_wr_rdy, 32'd1);
    d_rd_req = 1'b0; d_wr_req = 1'b0;
    step();
    check("post_rst_arvalid", arvalid, 32'd0);
    check("post_rst_awvalid", awvalid, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
